// File: rtl/snes_port_pkg.sv
// rtl/snes_port_pkg.sv - shared constants for the SNES controller port logic
package snes_port_pkg;

  // Button positions inside a 12-bit JOY word, MSB is sent first
  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  localparam int SR_LEN_DEF   = 16;
  localparam int PAD_BITS_DEF = 12;

  // Standard pad identification nibble, sent after the buttons
  localparam logic [3:0] PAD_ID = 4'b0000;

endpackage

// File: rtl/snes_pad_shifter.sv
// rtl/snes_pad_shifter.sv - one pad's line-level serial shift register
module snes_pad_shifter
  import snes_port_pkg::*;
#(
  parameter int SR_LEN   = SR_LEN_DEF,
  parameter int PAD_BITS = PAD_BITS_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                LOAD,
  input  logic                SHIFT,
  input  logic                CONN,
  input  logic [PAD_BITS-1:0] BTN,
  output logic                DOUT
);

  logic [SR_LEN-1:0] sr;
  // Connection state is frozen at load so a mid-read unplug cannot change the tail bits
  logic              conn_q;

  // Load on latch (released word if unplugged), otherwise shift left on request
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sr     <= '1;
      conn_q <= 1'b0;
    end else if (LOAD) begin
      sr     <= CONN ? ~{BTN, PAD_ID} : '1;
      conn_q <= CONN;
    end else if (SHIFT) begin
      sr     <= {sr[SR_LEN-2:0], ~conn_q};
    end
  end

  assign DOUT = sr[SR_LEN-1];

endmodule

// File: rtl/snes_multitap.sv
// rtl/snes_multitap.sv - four-pad multitap on one SNES controller port
module snes_multitap
  import snes_port_pkg::*;
#(
  parameter int SR_LEN   = SR_LEN_DEF,
  parameter int PAD_BITS = PAD_BITS_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MT_EN,
  input  logic [3:0]          PAD_CONN,
  input  logic [PAD_BITS-1:0] JOY1,
  input  logic [PAD_BITS-1:0] JOY2,
  input  logic [PAD_BITS-1:0] JOY3,
  input  logic [PAD_BITS-1:0] JOY4,
  input  logic                PORT_LATCH,
  input  logic                PORT_CLK,
  input  logic                PORT_IOBIT,
  output logic [1:0]          PORT_DO
);

  logic       old_clk;
  logic       old_latch;
  logic       en_q;
  logic       clk_rise;
  logic       shift_any;
  logic [3:0] shift;
  logic [3:0] dout;
  logic [1:0] do_next;

  assign clk_rise  = PORT_CLK & ~old_clk;
  // Latch wins over a coincident clock rise
  assign shift_any = clk_rise & ~PORT_LATCH;

  // Only the selected pair advances, so the other pair keeps its read position
  assign shift[0] = shift_any & (~en_q | PORT_IOBIT);
  assign shift[1] = shift_any & en_q & PORT_IOBIT;
  assign shift[2] = shift_any & en_q & ~PORT_IOBIT;
  assign shift[3] = shift_any & en_q & ~PORT_IOBIT;

  snes_pad_shifter #(.SR_LEN(SR_LEN), .PAD_BITS(PAD_BITS)) u_pad1 (
    .CLK(CLK), .RESET(RESET), .LOAD(PORT_LATCH), .SHIFT(shift[0]),
    .CONN(PAD_CONN[0]), .BTN(JOY1), .DOUT(dout[0]));
  snes_pad_shifter #(.SR_LEN(SR_LEN), .PAD_BITS(PAD_BITS)) u_pad2 (
    .CLK(CLK), .RESET(RESET), .LOAD(PORT_LATCH), .SHIFT(shift[1]),
    .CONN(PAD_CONN[1]), .BTN(JOY2), .DOUT(dout[1]));
  snes_pad_shifter #(.SR_LEN(SR_LEN), .PAD_BITS(PAD_BITS)) u_pad3 (
    .CLK(CLK), .RESET(RESET), .LOAD(PORT_LATCH), .SHIFT(shift[2]),
    .CONN(PAD_CONN[2]), .BTN(JOY3), .DOUT(dout[2]));
  snes_pad_shifter #(.SR_LEN(SR_LEN), .PAD_BITS(PAD_BITS)) u_pad4 (
    .CLK(CLK), .RESET(RESET), .LOAD(PORT_LATCH), .SHIFT(shift[3]),
    .CONN(PAD_CONN[3]), .BTN(JOY4), .DOUT(dout[3]));

  // Edge-detect history; mode is committed when the latch falls
  always_ff @(posedge CLK) begin
    if (RESET) begin
      old_clk   <= 1'b0;
      old_latch <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      old_clk   <= PORT_CLK;
      old_latch <= PORT_LATCH;
      if (old_latch && !PORT_LATCH) begin
        en_q <= MT_EN;
      end
    end
  end

  // Line mux: multitap signature during latch, else the selected pair or pad 1
  always_comb begin
    do_next = {1'b1, dout[0]};
    if (en_q) begin
      if (PORT_LATCH) begin
        do_next = {1'b0, dout[0]};
      end else if (PORT_IOBIT) begin
        do_next = {dout[1], dout[0]};
      end else begin
        do_next = {dout[3], dout[2]};
      end
    end
  end

  // Registered output pins
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PORT_DO <= 2'b11;
    end else begin
      PORT_DO <= do_next;
    end
  end

endmodule

// File: tb/tb_snes_multitap.sv
// tb/tb_snes_multitap.sv - directed self-checking bench for snes_multitap
module tb_snes_multitap;
  import snes_port_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MT_EN;
  logic [3:0]  PAD_CONN;
  logic [11:0] JOY1, JOY2, JOY3, JOY4;
  logic        PORT_LATCH;
  logic        PORT_CLK;
  logic        PORT_IOBIT;
  logic [1:0]  PORT_DO;

  int n_checks = 0;
  int n_fail   = 0;

  snes_multitap dut (
    .CLK(CLK), .RESET(RESET), .MT_EN(MT_EN), .PAD_CONN(PAD_CONN),
    .JOY1(JOY1), .JOY2(JOY2), .JOY3(JOY3), .JOY4(JOY4),
    .PORT_LATCH(PORT_LATCH), .PORT_CLK(PORT_CLK), .PORT_IOBIT(PORT_IOBIT),
    .PORT_DO(PORT_DO));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic latch_pulse();
    PORT_LATCH = 1'b1;
    tick(2);
    PORT_LATCH = 1'b0;
    tick(2);
  endtask

  task automatic clk_pulse();
    PORT_CLK = 1'b1;
    tick(2);
    PORT_CLK = 1'b0;
    tick(2);
  endtask

  // Line level of one pad's bit k: buttons (active low), then ID 1s, then 0s
  function automatic logic bit_of(input logic [11:0] joy, input int k);
    if (k < 12) return ~joy[11-k];
    else if (k < 16) return 1'b1;
    else return 1'b0;
  endfunction

  initial begin
    RESET = 1'b1; MT_EN = 1'b0; PAD_CONN = 4'hF;
    JOY1 = '0; JOY2 = '0; JOY3 = '0; JOY4 = '0;
    PORT_LATCH = 1'b0; PORT_CLK = 1'b0; PORT_IOBIT = 1'b1;

    // Reset state
    tick(2);
    check("reset_do", {14'd0, PORT_DO}, 16'h0003);
    RESET = 1'b0;
    tick(2);
    clk_pulse();
    check("reset_shift_d0", {15'd0, PORT_DO[0]}, 16'h0001);

    // Single pad, B pressed, 17 bits
    MT_EN = 1'b0; JOY1 = 12'h800;
    latch_pulse();
    for (int k = 0; k < 17; k++) begin
      check($sformatf("single_bit%0d", k), {14'd0, PORT_DO}, {14'd0, 1'b1, bit_of(12'h800, k)});
      clk_pulse();
    end

    // Pair 1/2: R on pad 1, Y on pad 2
    MT_EN = 1'b1; PORT_IOBIT = 1'b1; JOY1 = 12'h001; JOY2 = 12'h400;
    latch_pulse();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("pair12_bit%0d", k), {14'd0, PORT_DO},
            {14'd0, (k == 1) ? 1'b0 : 1'b1, (k == 11) ? 1'b0 : 1'b1});
      clk_pulse();
    end

    // Pair 3/4 after a partial read of pair 1/2
    JOY1 = 12'h040; JOY2 = 12'h020; JOY3 = 12'h800; JOY4 = 12'h000;
    PORT_IOBIT = 1'b1;
    latch_pulse();
    for (int k = 0; k < 5; k++) clk_pulse();
    PORT_IOBIT = 1'b0;
    tick(2);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("pair34_bit%0d", k), {14'd0, PORT_DO},
            {14'd0, 1'b1, (k == 0) ? 1'b0 : 1'b1});
      clk_pulse();
    end
    PORT_IOBIT = 1'b1;
    tick(2);
    check("resume12_bit5", {14'd0, PORT_DO}, 16'h0002);
    clk_pulse();
    check("resume12_bit6", {14'd0, PORT_DO}, 16'h0001);

    // Multitap signature during latch, pad 4 unplugged but pressed
    JOY1 = 12'h800; JOY3 = 12'h000; JOY4 = 12'hFFF; PAD_CONN = 4'b0111;
    PORT_LATCH = 1'b1;
    tick(3);
    check("signature", {14'd0, PORT_DO}, 16'h0000);
    PORT_LATCH = 1'b0;
    PORT_IOBIT = 1'b0;
    tick(2);
    for (int k = 0; k < 18; k++) begin
      check($sformatf("discon_bit%0d", k), {14'd0, PORT_DO},
            {14'd0, 1'b1, bit_of(12'h000, k)});
      clk_pulse();
    end

    // Latch/clock collision: the rise is swallowed by the latch
    PAD_CONN = 4'hF; MT_EN = 1'b0; JOY1 = 12'h800; PORT_IOBIT = 1'b1;
    PORT_LATCH = 1'b1; PORT_CLK = 1'b1;
    tick(2);
    PORT_LATCH = 1'b0;
    tick(2);
    PORT_CLK = 1'b0;
    tick(2);
    check("collide_bit0", {14'd0, PORT_DO}, 16'h0002);
    clk_pulse();
    check("collide_bit1", {14'd0, PORT_DO}, 16'h0003);

    // Reset beats a simultaneous latch
    MT_EN = 1'b1;
    RESET = 1'b1; PORT_LATCH = 1'b1;
    tick(2);
    check("reset_over_latch", {14'd0, PORT_DO}, 16'h0003);
    RESET = 1'b0; PORT_LATCH = 1'b0;
    tick(2);
    check("reset_sr_released", {14'd0, PORT_DO}, 16'h0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
